// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin per-cycle grant, lockable bursts.
// Build option DMEM_ARB_FIXED_PRIO_EN: IDLE contention always goes to port 0.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req0,
  input  logic              We0,
  input  logic              Lock0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Gnt0,
  output logic              RValid0,
  output logic [DATA_W-1:0] RData0,
  input  logic              Req1,
  input  logic              We1,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt1,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData1,
  output logic              MemLoad,
  output logic              MemStore,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   tie_to_1;

  // Handshake: a requester raises Req with We/Addr/WData and holds them until Gnt;
  // Gnt high means the access is performed in that same cycle.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie_to_1 = 1'b0;
`else
  assign tie_to_1 = ~last;
`endif

  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (Req0 && Req1) begin
            Gnt0 = ~tie_to_1;
            Gnt1 = tie_to_1;
          end else begin
            Gnt0 = Req0;
            Gnt1 = Req1;
          end
        end
        OWN0:    Gnt0 = Req0;
        OWN1:    Gnt1 = Req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    MemLoad    = 1'b0;
    MemStore   = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (Gnt0) begin
      MemLoad    = ~We0;
      MemStore   = We0;
      MemAddress = Addr0;
      MemDataIn  = WData0;
    end else if (Gnt1) begin
      MemLoad    = ~We1;
      MemStore   = We1;
      MemAddress = Addr1;
      MemDataIn  = WData1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      RData0  <= '0;
      RData1  <= '0;
    end else begin
      RValid0 <= Gnt0 & ~We0;
      RValid1 <= Gnt1 & ~We1;
      if (Gnt0 && !We0) RData0 <= MemDataOut;
      if (Gnt1 && !We1) RData1 <= MemDataOut;
      if (Gnt0)      last <= 1'b0;
      else if (Gnt1) last <= 1'b1;
      // An owner keeps the bus while its Lock stays high, even through idle cycles.
      unique case (state)
        IDLE: begin
          if (Gnt0 && Lock0)      state <= OWN0;
          else if (Gnt1 && Lock1) state <= OWN1;
        end
        OWN0:    if (!Lock0) state <= IDLE;
        OWN1:    if (!Lock1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Provides per-cycle round-robin arbitration with optional bus lock for multi-word bursts.
- Drives the memory's Load/Store/Address/DataIn pins and returns read data registered one cycle after grant with a valid strobe.

Parameters:
- ADDR_W, 10, word-address width (1024-word memory)
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- Req0  in  1  port 0 access request; held until Gnt0
- We0  in  1  port 0: 1 = store, 0 = load
- Lock0  in  1  port 0 requests ownership beyond the current access
- Addr0  in  ADDR_W  port 0 word address
- WData0  in  DATA_W  port 0 store data
- Gnt0  out  1  port 0 access performed this cycle
- RValid0  out  1  port 0 read data valid
- RData0  out  DATA_W  port 0 read data
- Req1, We1, Lock1, Addr1, WData1, Gnt1, RValid1, RData1: same as port 0, for port 1
- MemLoad  out  1  to memory Load
- MemStore  out  1  to memory Store
- MemAddress  out  ADDR_W  to memory Address
- MemDataIn  out  DATA_W  to memory DataIn
- MemDataOut  in  DATA_W  from memory DataOut (combinational read)

Behaviour:
- States: IDLE, OWN0, OWN1 (2-bit register). Also a round-robin pointer Last (1 bit; last port granted).
- Reset (rst_n low at posedge): state=IDLE, Last=1 (port 0 wins the first tie), RValid0/1=0, RData0/1=0.
- Gnt0/1, MemLoad and MemStore are forced 0 in any cycle rst_n is low.
- Grant is combinational in the same cycle; at most one Gnt high per cycle.
  - IDLE: only one Req high -> grant it. Both high -> grant port != Last.
  - OWNn: grant port n if Reqn; the other port is never granted.
- Memory drive:
  - Gnt high -> MemAddress, MemDataIn from the granted port; MemStore = We; MemLoad = ~We.
  - No grant -> MemLoad = MemStore = 0; MemAddress/MemDataIn = 0.
- Store commits in memory at the posedge ending the grant cycle.
- Load: MemDataOut captured at the posedge ending the grant cycle into RDatan. RValidn=1 for exactly the following cycle, then 0. RDatan holds its value until the next load to that port.
  - Latency: request-to-data 1 cycle when uncontended.
- Last updates to the granted port on every grant.
- State transitions at posedge:
  - Grant to n with Lockn=1 -> OWNn.
  - In OWNn, Lockn=0 sampled (with or without Reqn) -> IDLE.
  - In OWNn, Reqn=0 and Lockn=1 -> stay OWNn; idle cycle, other port starves.
  - Grant with Lockn=0 -> IDLE.
- Back-to-back grants to the same port are allowed every cycle; RValid may be high continuously.
- Store followed by load to the same address on the next cycle returns the new data.
- Requester must hold Req/We/Addr/WData stable until Gnt. Changing them before Gnt is illegal; behaviour is undefined.
- Reset mid-operation: a pending RValid is dropped, ownership is released, and a store in the reset cycle is not issued.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
  - Defined: IDLE contention always grants port 0. Last is still maintained but unused.
  - Undefined: round-robin as above.
- Lock semantics are identical in both builds.

Test Plan:
- Reset, then Req0 load Addr0=0x005 (mem[5]=0xDEADBEEF) -> Gnt0 same cycle, next cycle RValid0=1, RData0=0xDEADBEEF, Gnt1=0.
- Req0 and Req1 both held, loads, 4 cycles -> grants 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN -> 0,0,0,0, Gnt1 never high.
- Port1 store Addr1=0x3FF, WData1=0x12345678, then port0 load 0x3FF next cycle -> RData0=0x12345678 one cycle after Gnt0.
- Port1 Lock1=1 for 3 stores while Req0 held -> Gnt1 ×3, Gnt0=0. Lock1 drops -> Gnt0 in the first cycle after return to IDLE.
- rst_n low in the cycle after a port0 load grant -> RValid0=0 next cycle, MemStore/MemLoad=0 during reset, first post-reset contention grants port 0.
